cordic_vectoring_iter: RTL and testbench

- Inverse-direction companion to the rotation-mode sin/cos pipeline: a vectoring-mode CORDIC that takes a Cartesian pair (x, y) and returns the magnitude and the angle atan2(y, x).
- Iterative architecture: one micro-rotation per clock, one shared add/shift datapath, valid/ready handshakes on both sides.
- Sits downstream of data producers that need phase/magnitude recovery, e.g. checking the rotation pipeline's outputs.

---
 rtl/cordic_vectoring_iter.sv | 212 +++++++++++++++++++++
 tb/tb_cordic_vectoring_iter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/cordic_vectoring_iter.sv
// Iterative vectoring-mode CORDIC: (x, y) -> raw-gain magnitude and atan2(y, x), one micro-rotation per clock.
// Optional macro CORDIC_VEC_GAIN_COMP_EN adds a one-cycle gain-compensation multiply so mag_out ~ |v|.
module cordic_vectoring_iter #(
  parameter int DATA_W = 32,
  parameter int ITER   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] x_in,
  input  logic signed [DATA_W-1:0] y_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W+2:0]        mag_out,
  output logic signed [31:0]       angle_out,
  output logic                     zero_in
);

  localparam int IW = DATA_W + 3;
  localparam logic [4:0]         LAST_I   = 5'(ITER - 1);
  localparam logic signed [31:0] HALF_PI  = 32'sh3243F6A9;
  localparam logic signed [33:0] PI_Q     = 34'sd1686629713;
  localparam logic signed [33:0] TWO_PI_Q = 34'sd3373259426;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_ITER,
    S_GAIN,
    S_DONE
  } state_t;

  // atan(2^-i) in Q3.29, rounded to nearest
  function automatic logic signed [31:0] atan_tab(input logic [4:0] idx);
    case (idx)
      5'd0:    atan_tab = 32'sh1921FB54;
      5'd1:    atan_tab = 32'sh0ED63383;
      5'd2:    atan_tab = 32'sh07D6DD7E;
      5'd3:    atan_tab = 32'sh03FAB753;
      5'd4:    atan_tab = 32'sh01FF55BB;
      5'd5:    atan_tab = 32'sh00FFEAAE;
      5'd6:    atan_tab = 32'sh007FFD55;
      5'd7:    atan_tab = 32'sh003FFFAB;
      5'd8:    atan_tab = 32'sh001FFFF5;
      5'd9:    atan_tab = 32'sh000FFFFF;
      5'd10:   atan_tab = 32'sh00080000;
      5'd11:   atan_tab = 32'sh00040000;
      5'd12:   atan_tab = 32'sh00020000;
      5'd13:   atan_tab = 32'sh00010000;
      5'd14:   atan_tab = 32'sh00008000;
      5'd15:   atan_tab = 32'sh00004000;
      5'd16:   atan_tab = 32'sh00002000;
      5'd17:   atan_tab = 32'sh00001000;
      5'd18:   atan_tab = 32'sh00000800;
      5'd19:   atan_tab = 32'sh00000400;
      5'd20:   atan_tab = 32'sh00000200;
      5'd21:   atan_tab = 32'sh00000100;
      5'd22:   atan_tab = 32'sh00000080;
      5'd23:   atan_tab = 32'sh00000040;
      5'd24:   atan_tab = 32'sh00000020;
      5'd25:   atan_tab = 32'sh00000010;
      5'd26:   atan_tab = 32'sh00000008;
      5'd27:   atan_tab = 32'sh00000004;
      5'd28:   atan_tab = 32'sh00000002;
      5'd29:   atan_tab = 32'sh00000001;
      default: atan_tab = 32'sh00000000;
    endcase
  endfunction

  state_t                 state_q, state_d;
  logic signed [IW-1:0]   x_q, x_d, y_q, y_d;
  logic signed [31:0]     z_q, z_d;
  logic [4:0]             i_q, i_d;
  logic                   zero_q, zero_d;
  logic                   out_valid_q, out_valid_d;
  logic [IW-1:0]          mag_out_q, mag_out_d;
  logic signed [31:0]     angle_out_q, angle_out_d;
  logic                   zero_in_q, zero_in_d;

  logic signed [IW-1:0]   x_sh, y_sh;
  logic signed [33:0]     z_ext, z_wrap;

  assign x_sh  = x_q >>> i_q;
  assign y_sh  = y_q >>> i_q;
  assign z_ext = {{2{z_q[31]}}, z_q};

`ifdef CORDIC_VEC_GAIN_COMP_EN
  localparam logic signed [31:0] GAIN_K = 32'sh26DD3B6A;
  logic signed [IW+31:0] prod;
  assign prod = x_q * GAIN_K;
`endif

  // Residual angle can overshoot +/-pi slightly; fold it back, leaving exactly +pi alone.
  always_comb begin
    if (z_ext > PI_Q)       z_wrap = z_ext - TWO_PI_Q;
    else if (z_ext < -PI_Q) z_wrap = z_ext + TWO_PI_Q;
    else                    z_wrap = z_ext;
  end

  always_comb begin
    // NOTE: each _d defaults to its held value first, so no branch below can infer a latch.
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    i_d         = i_q;
    zero_d      = zero_q;
    out_valid_d = out_valid_q;
    mag_out_d   = mag_out_q;
    angle_out_d = angle_out_q;
    zero_in_d   = zero_in_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          x_d     = {{3{x_in[DATA_W-1]}}, x_in};
          y_d     = {{3{y_in[DATA_W-1]}}, y_in};
          z_d     = '0;
          zero_d  = (x_in == '0) && (y_in == '0);
          state_d = S_PRE;
        end
      end
      S_PRE: begin
        if (x_q[IW-1] && !y_q[IW-1]) begin
          x_d = y_q;
          y_d = -x_q;
          z_d = HALF_PI;
        end else if (x_q[IW-1]) begin
          x_d = -y_q;
          y_d = x_q;
          z_d = -HALF_PI;
        end else begin
          z_d = '0;
        end
        i_d     = '0;
        state_d = S_ITER;
      end
      S_ITER: begin
        if (!y_q[IW-1]) begin
          x_d = x_q + y_sh;
          y_d = y_q - x_sh;
          z_d = z_q + atan_tab(i_q);
        end else begin
          x_d = x_q - y_sh;
          y_d = y_q + x_sh;
          z_d = z_q - atan_tab(i_q);
        end
        i_d = i_q + 5'd1;
        if (i_q == LAST_I) begin
`ifdef CORDIC_VEC_GAIN_COMP_EN
          state_d = S_GAIN;
`else
          state_d = S_DONE;
`endif
        end
      end
      S_GAIN: begin
`ifdef CORDIC_VEC_GAIN_COMP_EN
        x_d = IW'(prod >>> 30);
`endif
        state_d = S_DONE;
      end
      S_DONE: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          zero_in_d   = zero_q;
          mag_out_d   = zero_q ? '0 : $unsigned(x_q);
          angle_out_d = zero_q ? '0 : 32'(z_wrap);
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      i_q         <= '0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
      mag_out_q   <= '0;
      angle_out_q <= '0;
      zero_in_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      i_q         <= i_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
      mag_out_q   <= mag_out_d;
      angle_out_q <= angle_out_d;
      zero_in_q   <= zero_in_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign mag_out   = mag_out_q;
  assign angle_out = angle_out_q;
  assign zero_in   = zero_in_q;

endmodule

// File: tb/tb_cordic_vectoring_iter.sv
// Directed-vector bench for cordic_vectoring_iter: table of (x, y) with expected angle/magnitude,
// plus handshake-hold, back-to-back and mid-operation reset sequences.
`timescale 1ns/1ps
module tb_cordic_vectoring_iter;

  localparam int  DATA_W = 32;
  localparam int  ITER   = 16;
`ifdef CORDIC_VEC_GAIN_COMP_EN
  localparam int  LAT    = ITER + 3;
  localparam real GAIN   = 1.0;
`else
  localparam int  LAT    = ITER + 2;
  localparam real GAIN   = 1.646760258;
`endif
  localparam real PI_R      = 3.14159265358979;
  localparam real SCALE_IN  = 1073741824.0;
  localparam real SCALE_ANG = 536870912.0;
  localparam real ANG_TOL   = 20000.0;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] x_in;
  logic signed [DATA_W-1:0] y_in;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_W+2:0]        mag_out;
  logic signed [31:0]       angle_out;
  logic                     zero_in;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cordic_vectoring_iter #(.DATA_W(DATA_W), .ITER(ITER)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in), .y_in(y_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .mag_out(mag_out), .angle_out(angle_out), .zero_in(zero_in)
  );

  typedef struct {
    string       name;
    logic [31:0] x;
    logic [31:0] y;
    real         ang;
    real         mag;
    bit          zero;
  } vec_t;

  function automatic vec_t mk(input string n, input logic [31:0] x, input logic [31:0] y,
                              input real ang, input real mag, input bit zero);
    vec_t v;
    v.name = n; v.x = x; v.y = y; v.ang = ang; v.mag = mag; v.zero = zero;
    return v;
  endfunction

  task automatic check(input string name, input bit ok, input string detail);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  // Angle error in output LSBs, measured around the circle so +pi and -pi coincide.
  function automatic real ang_err(input logic signed [31:0] a, input real exp_rad);
    real d;
    d = $itor(a) / SCALE_ANG - exp_rad;
    while (d > PI_R)  d = d - 2.0 * PI_R;
    while (d < -PI_R) d = d + 2.0 * PI_R;
    return d * SCALE_ANG;
  endfunction

  task automatic start_op(input string name, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    x_in = x;
    y_in = y;
    in_valid = 1'b1;
    check({name, "_in_ready"}, in_ready === 1'b1, $sformatf("in_ready got %b want 1", in_ready));
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic release_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic check_result(input vec_t v);
    real e, exp_mag, tol;
    e = ang_err(angle_out, v.ang);
    if (v.zero) begin
      check({v.name, "_angle"}, angle_out === 32'sd0, $sformatf("angle got %h want 0", angle_out));
    end else begin
      check({v.name, "_angle"}, (e <= ANG_TOL) && (e >= -ANG_TOL),
            $sformatf("angle got %h want %f rad (err %0.1f lsb)", angle_out, v.ang, e));
    end
    exp_mag = GAIN * v.mag * SCALE_IN;
`ifdef CORDIC_VEC_GAIN_COMP_EN
    tol = v.zero ? 0.0 : 8192.0;
`else
    tol = exp_mag * 1.0e-4;
`endif
    check({v.name, "_mag"}, ($itor(mag_out) - exp_mag <= tol) && (exp_mag - $itor(mag_out) <= tol),
          $sformatf("mag got %h want %0.1f +/- %0.1f", mag_out, exp_mag, tol));
    check({v.name, "_zero"}, zero_in === v.zero, $sformatf("zero_in got %b want %b", zero_in, v.zero));
  endtask

  vec_t vecs[10];

  initial begin
    int   lat;
    logic [DATA_W+2:0]  mag_hold;
    logic signed [31:0] ang_hold;
    bit   stable;
    bit   quiet;

    vecs[0] = mk("pos_x",     32'h40000000, 32'h00000000, 0.0,            1.0,          1'b0);
    vecs[1] = mk("pos_y",     32'h00000000, 32'h40000000, PI_R / 2.0,     1.0,          1'b0);
    vecs[2] = mk("diag_q1",   32'h40000000, 32'h40000000, PI_R / 4.0,     $sqrt(2.0),   1'b0);
    vecs[3] = mk("neg_x",     32'hC0000000, 32'h00000000, PI_R,           1.0,          1'b0);
    vecs[4] = mk("neg_x_eps", 32'hC0000000, 32'hFFFFFFFF, -PI_R,          1.0,          1'b0);
    vecs[5] = mk("diag_q4",   32'h20000000, 32'hE0000000, -PI_R / 4.0,    $sqrt(0.5),   1'b0);
    vecs[6] = mk("diag_q2",   32'hE0000000, 32'h20000000, 3.0 * PI_R / 4.0, $sqrt(0.5), 1'b0);
    vecs[7] = mk("q3_skew",   32'hA0000000, 32'hC0000000, $atan2(-1.0, -1.5), $sqrt(3.25), 1'b0);
    vecs[8] = mk("min_corner", 32'h80000000, 32'h80000000, -3.0 * PI_R / 4.0, 2.0 * $sqrt(2.0), 1'b0);
    vecs[9] = mk("zero_vec",  32'h00000000, 32'h00000000, 0.0,            0.0,          1'b1);

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; x_in = '0; y_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready === 1'b0, $sformatf("in_ready got %b want 0", in_ready));
    check("rst_outputs",
          out_valid === 1'b0 && mag_out === '0 && angle_out === 32'sd0 && zero_in === 1'b0,
          $sformatf("got v=%b mag=%h ang=%h z=%b want all 0", out_valid, mag_out, angle_out, zero_in));
    @(negedge clk);
    rst = 1'b0;
    #1 check("idle_in_ready", in_ready === 1'b1, $sformatf("in_ready got %b want 1", in_ready));

    for (int k = 0; k < 10; k++) begin
      start_op(vecs[k].name, vecs[k].x, vecs[k].y);
      wait_valid(lat);
      check({vecs[k].name, "_latency"}, lat == LAT, $sformatf("latency got %0d want %0d", lat, LAT));
      check_result(vecs[k]);
      release_result();
    end

    // Back-pressure: outputs frozen and no new input accepted while the result is pending.
    start_op("hold", vecs[2].x, vecs[2].y);
    wait_valid(lat);
    mag_hold = mag_out;
    ang_hold = angle_out;
    stable = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || mag_out !== mag_hold || angle_out !== ang_hold)
        stable = 1'b0;
    end
    check("hold_stable", stable, $sformatf("last v=%b rdy=%b mag=%h ang=%h want 1/0/%h/%h",
          out_valid, in_ready, mag_out, angle_out, mag_hold, ang_hold));
    check_result(vecs[2]);
    release_result();
    check("hold_release", in_ready === 1'b1 && out_valid === 1'b0,
          $sformatf("in_ready=%b out_valid=%b want 1/0", in_ready, out_valid));
    start_op("b2b", vecs[6].x, vecs[6].y);
    wait_valid(lat);
    check("b2b_latency", lat == LAT, $sformatf("latency got %0d want %0d", lat, LAT));
    check_result(vecs[6]);
    release_result();

    // Reset in the middle of the iterations abandons the operation.
    start_op("midrst", vecs[0].x, vecs[0].y);
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 check("midrst_in_ready_low", in_ready === 1'b0, $sformatf("in_ready got %b want 0", in_ready));
    @(negedge clk);
    rst = 1'b0;
    #1 check("midrst_idle", in_ready === 1'b1 && out_valid === 1'b0,
             $sformatf("in_ready=%b out_valid=%b want 1/0", in_ready, out_valid));
    quiet = 1'b1;
    repeat (LAT + 5) begin
      @(posedge clk);
      #1 if (out_valid !== 1'b0) quiet = 1'b0;
    end
    check("midrst_no_valid", quiet, "out_valid rose after reset want 0");
    start_op("post_rst", vecs[7].x, vecs[7].y);
    wait_valid(lat);
    check("post_rst_latency", lat == LAT, $sformatf("latency got %0d want %0d", lat, LAT));
    check_result(vecs[7]);
    release_result();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
